// File: rtl/frame_task_scheduler.sv
// frame_task_scheduler: fires one game-logic sequence per frame at the first
// blanking line and grants four update tasks in order with a per-task timeout.
module frame_task_scheduler #(
    parameter int VFP     = 511,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        run,
    input  logic [3:0]  task_en,
    input  logic [3:0]  task_done,
    input  logic        clear_flags,
    output logic [3:0]  task_req,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic [3:0]  timeout_flag
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [9:0]  VFP_LINE = 10'(VFP);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  idx_r;
    logic [1:0]  next_idx_s;
    logic [15:0] tmo_cnt_r;
    logic        trig_r;
    logic        tmo_hit_s;
    logic        task_end_s;
    logic [3:0]  req_next_s;
    logic        busy_next_s;
    logic [3:0]  tmo_set_s;
    logic        ovr_set_s;
    logic [3:0]  task_req_r;
    logic        busy_r;
    logic [15:0] frame_cnt_r;
    logic        overrun_r;
    logic [3:0]  timeout_flag_r;

    // Start-of-blanking trigger, one pulse per frame while running.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            trig_r <= 1'b0;
        end else begin
            trig_r <= (hc == 10'd0) && (vc == VFP_LINE) && run;
        end
    end

    // Sequencer state and current task index.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= next_state_s;
            idx_r   <= next_idx_s;
        end
    end

    // Next-state decode; a task ends on done or when its grant budget runs out.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        tmo_hit_s    = 1'b0;
        task_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_r) begin
                    next_state_s = ST_ISSUE;
                    next_idx_s   = 2'd0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (task_en[idx_r]) begin
                    next_state_s = ST_WAIT;
                end else if (idx_r == 2'd3) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ISSUE;
                    next_idx_s   = idx_r + 2'd1;
                end
            end
            ST_WAIT: begin
                if (task_done[idx_r]) begin
                    task_end_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    task_end_s = 1'b1;
                    tmo_hit_s  = 1'b1;
                end else begin
                    task_end_s = 1'b0;
                end
                if (task_end_s && (idx_r == 2'd3)) begin
                    next_state_s = ST_DONE;
                end else if (task_end_s) begin
                    next_state_s = ST_ISSUE;
                    next_idx_s   = idx_r + 2'd1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_idx_s   = 2'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the grant and busy are registered.
    always_comb begin
        req_next_s  = 4'b0000;
        busy_next_s = 1'b0;
        if (next_state_s == ST_WAIT) begin
            req_next_s = onehot4(next_idx_s);
        end else begin
            req_next_s = 4'b0000;
        end
        if (next_state_s != ST_IDLE) begin
            busy_next_s = 1'b1;
        end else begin
            busy_next_s = 1'b0;
        end
    end

    // Sticky-flag set events.
    always_comb begin
        tmo_set_s = 4'b0000;
        ovr_set_s = trig_r && (state_r != ST_IDLE);
        if (tmo_hit_s) begin
            tmo_set_s = onehot4(idx_r);
        end else begin
            tmo_set_s = 4'b0000;
        end
    end

    // Grant-age counter, restarted on every issue.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ST_ISSUE) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ST_WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Registered grant, busy and completed-sequence count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            task_req_r  <= 4'b0000;
            busy_r      <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            task_req_r <= req_next_s;
            busy_r     <= busy_next_s;
            if (state_r == ST_DONE) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a clear is kept.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            overrun_r      <= 1'b0;
            timeout_flag_r <= 4'b0000;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clear_flags) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (clear_flags) begin
                timeout_flag_r <= tmo_set_s;
            end else begin
                timeout_flag_r <= timeout_flag_r | tmo_set_s;
            end
        end
    end

    assign task_req     = task_req_r;
    assign busy         = busy_r;
    assign frame_cnt    = frame_cnt_r;
    assign overrun      = overrun_r;
    assign timeout_flag = timeout_flag_r;
endmodule
